// File: rtl/hyper_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hyper_rx_pkg
// Description : Shared types and constants for the HyperBus/PSRAM read-beat
//               controller.
// Revision    : 1.0 - initial release
// ============================================================================
package hyper_rx_pkg;

  // Controller states; explicit 2-bit encoding
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } rx_beat_state_e;

  // mem_sel value that selects 32-bit PHY beats
  localparam logic [1:0] MEM_SEL_32B = 2'b11;

  // Bytes carried by one PHY beat in each mode
  localparam int BEAT_BYTES_16 = 2;
  localparam int BEAT_BYTES_32 = 4;

endpackage : hyper_rx_pkg
`default_nettype wire

// File: rtl/hyper_rx_beat_fifo.sv
`default_nettype none
// ============================================================================
// Module      : hyper_rx_beat_fifo
// Description : Small synchronous beat FIFO (not fall-through). A push into
//               a full FIFO is accepted when a pop happens in the same cycle.
//               Flush empties the FIFO and has priority over push/pop.
// Revision    : 1.0 - initial release
// ============================================================================
module hyper_rx_beat_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             empty_o,
  output logic             push_accept_o
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW:0]      count;
  logic             full;
  logic             pop_ok;
  logic             push_ok;

  assign full          = (count == FULL_CNT);
  assign empty_o       = (count == '0);
  assign pop_ok        = pop_i & ~empty_o;
  assign push_ok       = push_i & (~full | pop_ok);
  assign push_accept_o = push_ok & ~flush_i;
  // Head entry is only rewritten after it has been popped, so it is stable
  // while it is presented.
  assign data_o        = mem[rd_ptr];

  // Storage array: written on an accepted push
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push_ok && !flush_i) begin
      mem[wr_ptr] <= data_i;
    end
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule : hyper_rx_beat_fifo
`default_nettype wire

// File: rtl/hyper_rx_beat_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hyper_rx_beat_ctrl
// Description : Per-transaction read-beat controller between the HyperBus
//               PHY read path and the uDMA rx buffer. Absorbs unstallable PHY
//               beats into a FIFO, tracks remaining beats, reports done and
//               overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module hyper_rx_beat_ctrl #(
  parameter int TRANS_SIZE = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  output logic                  start_ready_o,
  input  logic [TRANS_SIZE-1:0] cfg_rx_size_i,
  input  logic [1:0]            cfg_addr_lsb_i,
  input  logic [1:0]            mem_sel_i,
  input  logic                  abort_i,
  input  logic                  phy_valid_i,
  input  logic [31:0]           phy_data_i,
  output logic                  src_valid_o,
  input  logic                  src_ready_i,
  output logic [31:0]           data_o,
  output logic [TRANS_SIZE-1:0] remained_data_o,
  output logic                  hyper_odd_saaddr_o,
  output logic                  done_o,
  output logic                  err_overflow_o
);

  import hyper_rx_pkg::*;

  rx_beat_state_e        state;
  logic [TRANS_SIZE-1:0] beats_total;
  logic [TRANS_SIZE-1:0] take_cnt;
  logic [TRANS_SIZE-1:0] remained;
  logic [TRANS_SIZE-1:0] remained_next;
  logic [TRANS_SIZE-1:0] beats_calc;
  logic [TRANS_SIZE:0]   size_sum;
  logic                  off;
  logic                  odd;
  logic                  err;
  logic                  done;
  logic                  phy_take;
  logic                  push_accept;
  logic                  drop;
  logic                  pop;
  logic                  fifo_empty;
  logic [1:0]            dec;

  // Beat count of the incoming descriptor: ceil((size + offset bytes) / beat)
  always_comb begin
    off        = 1'b0;
    size_sum   = '0;
    beats_calc = '0;
    if (mem_sel_i == MEM_SEL_32B) begin
      off        = cfg_addr_lsb_i[1];
      size_sum   = {1'b0, cfg_rx_size_i} + (TRANS_SIZE+1)'({off, 1'b0})
                 + (TRANS_SIZE+1)'(BEAT_BYTES_32 - 1);
      beats_calc = TRANS_SIZE'(size_sum >> 2);
    end else begin
      off        = cfg_addr_lsb_i[0];
      size_sum   = {1'b0, cfg_rx_size_i} + (TRANS_SIZE+1)'(off)
                 + (TRANS_SIZE+1)'(BEAT_BYTES_16 - 1);
      beats_calc = TRANS_SIZE'(size_sum >> 1);
    end
  end

  // Beat accounting: a dropped beat counts as delivered so the count still ends at 0
  always_comb begin
    phy_take      = (state == ST_RUN) & phy_valid_i & (take_cnt != beats_total) & ~abort_i;
    pop           = ~fifo_empty & src_ready_i;
    drop          = phy_take & ~push_accept;
    dec           = {1'b0, pop} + {1'b0, drop};
    remained_next = (remained > TRANS_SIZE'(dec)) ? (remained - TRANS_SIZE'(dec)) : '0;
  end

  hyper_rx_beat_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .flush_i       (abort_i),
    .push_i        (phy_take),
    .data_i        (phy_data_i),
    .pop_i         (pop),
    .data_o        (data_o),
    .empty_o       (fifo_empty),
    .push_accept_o (push_accept)
  );

  // Transaction state machine with registered status outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= ST_IDLE;
      beats_total <= '0;
      take_cnt    <= '0;
      remained    <= '0;
      odd         <= 1'b0;
      err         <= 1'b0;
      done        <= 1'b0;
    end else if (abort_i) begin
      state    <= ST_IDLE;
      take_cnt <= '0;
      remained <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            beats_total <= beats_calc;
            remained    <= beats_calc;
            take_cnt    <= '0;
            odd         <= off;
            err         <= 1'b0;
            if (beats_calc == '0) begin
              done <= 1'b1;
            end else begin
              state <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          remained <= remained_next;
          if (phy_take) take_cnt <= take_cnt + TRANS_SIZE'(1);
          if (drop)     err      <= 1'b1;
          if (remained_next == '0) begin
            done  <= 1'b1;
            state <= ST_IDLE;
          end else if (phy_take && (take_cnt + TRANS_SIZE'(1) == beats_total)) begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          remained <= remained_next;
          if (remained_next == '0) begin
            done  <= 1'b1;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign start_ready_o      = (state == ST_IDLE);
  assign src_valid_o        = ~fifo_empty;
  assign remained_data_o    = remained;
  assign hyper_odd_saaddr_o = odd;
  assign done_o             = done;
  assign err_overflow_o     = err;

endmodule : hyper_rx_beat_ctrl
`default_nettype wire

// File: tb/tb_hyper_rx_beat_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hyper_rx_beat_ctrl
// Description : Directed self-checking bench for hyper_rx_beat_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hyper_rx_beat_ctrl;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        start_i = 1'b0;
  logic        start_ready_o;
  logic [15:0] cfg_rx_size_i = '0;
  logic [1:0]  cfg_addr_lsb_i = '0;
  logic [1:0]  mem_sel_i = '0;
  logic        abort_i = 1'b0;
  logic        phy_valid_i = 1'b0;
  logic [31:0] phy_data_i = '0;
  logic        src_valid_o;
  logic        src_ready_i = 1'b0;
  logic [31:0] data_o;
  logic [15:0] remained_data_o;
  logic        hyper_odd_saaddr_o;
  logic        done_o;
  logic        err_overflow_o;

  int n_checks = 0;
  int n_errors = 0;

  hyper_rx_beat_ctrl #(
    .TRANS_SIZE (16),
    .FIFO_DEPTH (4)
  ) dut (
    .clk_i              (clk),
    .rst_ni             (rst_ni),
    .start_i            (start_i),
    .start_ready_o      (start_ready_o),
    .cfg_rx_size_i      (cfg_rx_size_i),
    .cfg_addr_lsb_i     (cfg_addr_lsb_i),
    .mem_sel_i          (mem_sel_i),
    .abort_i            (abort_i),
    .phy_valid_i        (phy_valid_i),
    .phy_data_i         (phy_data_i),
    .src_valid_o        (src_valid_o),
    .src_ready_i        (src_ready_i),
    .data_o             (data_o),
    .remained_data_o    (remained_data_o),
    .hyper_odd_saaddr_o (hyper_odd_saaddr_o),
    .done_o             (done_o),
    .err_overflow_o     (err_overflow_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_desc(input logic [15:0] size, input logic [1:0] lsb, input logic [1:0] sel);
    cfg_rx_size_i  = size;
    cfg_addr_lsb_i = lsb;
    mem_sel_i      = sel;
    start_i        = 1'b1;
    tick();
    start_i        = 1'b0;
  endtask

  initial begin
    // ---------------- reset values ----------------
    tick();
    tick();
    chk("rst_start_ready", 32'(start_ready_o), 32'd1);
    chk("rst_src_valid",   32'(src_valid_o),   32'd0);
    chk("rst_done",        32'(done_o),        32'd0);
    chk("rst_err",         32'(err_overflow_o), 32'd0);
    chk("rst_odd",         32'(hyper_odd_saaddr_o), 32'd0);
    chk("rst_remained",    32'(remained_data_o), 32'd0);
    chk("rst_data",        data_o,             32'd0);
    rst_ni = 1'b1;
    tick();

    // ---------------- 16-bit aligned, size 7 -> 4 beats ----------------
    src_ready_i = 1'b1;
    start_desc(16'd7, 2'd0, 2'b00);
    chk("t1_remained_start", 32'(remained_data_o), 32'd4);
    chk("t1_odd",            32'(hyper_odd_saaddr_o), 32'd0);
    chk("t1_start_ready",    32'(start_ready_o), 32'd0);
    for (int i = 0; i < 4; i++) begin
      phy_valid_i = 1'b1;
      phy_data_i  = 32'h0000_A100 + 32'(i);
      tick();
      chk("t1_valid", 32'(src_valid_o), 32'd1);
      chk("t1_data",  data_o, 32'h0000_A100 + 32'(i));
      chk("t1_remained", 32'(remained_data_o), 32'(4 - i));
    end
    phy_valid_i = 1'b0;
    tick();
    chk("t1_remained_end", 32'(remained_data_o), 32'd0);
    chk("t1_done",         32'(done_o), 32'd1);
    chk("t1_valid_end",    32'(src_valid_o), 32'd0);
    tick();
    chk("t1_done_pulse",   32'(done_o), 32'd0);
    chk("t1_ready_back",   32'(start_ready_o), 32'd1);

    // ---------------- 16-bit odd start, size 4 -> 3 beats, 5th discarded ----------------
    start_desc(16'd4, 2'd1, 2'b01);
    chk("t2_remained_start", 32'(remained_data_o), 32'd3);
    chk("t2_odd",            32'(hyper_odd_saaddr_o), 32'd1);
    for (int i = 0; i < 5; i++) begin
      phy_valid_i = 1'b1;
      phy_data_i  = 32'h0000_B200 + 32'(i);
      tick();
      if (i < 3) chk("t2_data", data_o, 32'h0000_B200 + 32'(i));
      if (i == 3) chk("t2_done", 32'(done_o), 32'd1);
    end
    phy_valid_i = 1'b0;
    chk("t2_valid_end", 32'(src_valid_o), 32'd0);
    chk("t2_no_err",    32'(err_overflow_o), 32'd0);
    chk("t2_remained",  32'(remained_data_o), 32'd0);
    chk("t2_odd_held",  32'(hyper_odd_saaddr_o), 32'd1);

    // ---------------- 32-bit, addr 2, size 8 -> 3 beats ----------------
    start_desc(16'd8, 2'd2, 2'b11);
    chk("t3_remained_start", 32'(remained_data_o), 32'd3);
    chk("t3_odd",            32'(hyper_odd_saaddr_o), 32'd1);
    for (int i = 0; i < 3; i++) begin
      phy_valid_i = 1'b1;
      phy_data_i  = 32'hC0DE_0000 + 32'(i * 32'h1111);
      tick();
      chk("t3_data", data_o, 32'hC0DE_0000 + 32'(i * 32'h1111));
    end
    phy_valid_i = 1'b0;
    tick();
    chk("t3_done", 32'(done_o), 32'd1);

    // ---------------- overflow under backpressure: 6 beats, depth 4 ----------------
    src_ready_i = 1'b0;
    start_desc(16'd12, 2'd0, 2'b00);
    chk("t4_remained_start", 32'(remained_data_o), 32'd6);
    for (int i = 0; i < 6; i++) begin
      phy_valid_i = 1'b1;
      phy_data_i  = 32'h0000_D400 + 32'(i);
      tick();
      if (i == 3) chk("t4_no_err_yet", 32'(err_overflow_o), 32'd0);
      if (i == 4) chk("t4_remained_drop1", 32'(remained_data_o), 32'd5);
    end
    phy_valid_i = 1'b0;
    chk("t4_err",          32'(err_overflow_o), 32'd1);
    chk("t4_remained",     32'(remained_data_o), 32'd4);
    chk("t4_head_stable",  data_o, 32'h0000_D400);
    tick();
    chk("t4_head_stable2", data_o, 32'h0000_D400);
    src_ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("t4_pop_data", data_o, 32'h0000_D400 + 32'(k));
      tick();
      chk("t4_pop_remained", 32'(remained_data_o), 32'(3 - k));
    end
    chk("t4_done",      32'(done_o), 32'd1);
    chk("t4_err_stick", 32'(err_overflow_o), 32'd1);
    tick();

    // ---------------- zero size ----------------
    start_desc(16'd0, 2'd0, 2'b00);
    chk("t5_done",        32'(done_o), 32'd1);
    chk("t5_start_ready", 32'(start_ready_o), 32'd1);
    chk("t5_valid",       32'(src_valid_o), 32'd0);
    chk("t5_err_cleared", 32'(err_overflow_o), 32'd0);
    tick();
    chk("t5_done_pulse",  32'(done_o), 32'd0);

    // ---------------- abort mid-RUN, then reset mid-RUN ----------------
    src_ready_i = 1'b0;
    start_desc(16'd16, 2'd0, 2'b00);
    chk("t6_remained_start", 32'(remained_data_o), 32'd8);
    for (int i = 0; i < 2; i++) begin
      phy_valid_i = 1'b1;
      phy_data_i  = 32'h0000_E600 + 32'(i);
      tick();
    end
    phy_valid_i = 1'b0;
    chk("t6_valid_before", 32'(src_valid_o), 32'd1);
    abort_i = 1'b1;
    start_i = 1'b1;
    tick();
    abort_i = 1'b0;
    chk("t6_flushed",     32'(src_valid_o), 32'd0);
    chk("t6_remained",    32'(remained_data_o), 32'd0);
    chk("t6_no_done",     32'(done_o), 32'd0);
    chk("t6_start_ready", 32'(start_ready_o), 32'd1);
    cfg_rx_size_i  = 16'd2;
    cfg_addr_lsb_i = 2'd1;
    mem_sel_i      = 2'b00;
    tick();
    start_i = 1'b0;
    chk("t6_restart",       32'(start_ready_o), 32'd0);
    chk("t6_restart_count", 32'(remained_data_o), 32'd2);
    chk("t6_restart_odd",   32'(hyper_odd_saaddr_o), 32'd1);
    phy_valid_i = 1'b1;
    phy_data_i  = 32'h0000_F7F7;
    tick();
    phy_valid_i = 1'b0;
    chk("t6_valid_pre_rst", 32'(src_valid_o), 32'd1);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("t6_rst_start_ready", 32'(start_ready_o), 32'd1);
    chk("t6_rst_valid",       32'(src_valid_o), 32'd0);
    chk("t6_rst_remained",    32'(remained_data_o), 32'd0);
    chk("t6_rst_odd",         32'(hyper_odd_saaddr_o), 32'd0);
    chk("t6_rst_data",        data_o, 32'd0);
    chk("t6_rst_done",        32'(done_o), 32'd0);
    chk("t6_rst_err",         32'(err_overflow_o), 32'd0);
    tick();
    rst_ni = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_hyper_rx_beat_ctrl
`default_nettype wire
